lcd_page_buffer: RTL and testbench

- Data re-arrangement buffer directly upstream of the LCD controller.
- On a page request it fetches one 64x8-pixel tile from the row-major 1-bpp image ROM and transposes it into 64 column bytes in KS0108 page format (bit r = pixel row r).
- Raises data_ack when the tile is ready, then serves bytes in order on data, advancing on rd_next.
- The LCD controller drives addr = {image[3:0], page[2:0]}; each addr value selects one tile.

---
 rtl/lcd_page_buffer_if.sv | 33 +++
 rtl/lcd_page_buffer.sv | 140 ++++++++++++++
 tb/tb_lcd_page_buffer.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_page_buffer_if.sv
// lcd_page_buffer_if: bus between the LCD controller, the page buffer and the image ROM.
// Signals:
//   data_request - level request for a new tile (controller -> buffer)
//   addr         - tile address {image, page}, sampled when a request is accepted
//   rd_next      - one-cycle strobe: advance to the next column byte
//   data_ack     - tile ready; held high until data_request is low
//   data         - column byte at the current read pointer
//   mem_rd       - ROM read enable
//   mem_addr     - ROM byte address {tile, row[2:0], bytecol[2:0]}
//   mem_data     - ROM read data, valid one cycle after mem_rd/mem_addr
// Modports: master = controller/ROM side, slave = page buffer.
interface lcd_page_buffer_if #(
    parameter int unsigned ADDR_W = 7
);
    logic                  data_request;
    logic [ADDR_W-1:0]     addr;
    logic                  rd_next;
    logic                  data_ack;
    logic [7:0]            data;
    logic                  mem_rd;
    logic [ADDR_W+5:0]     mem_addr;
    logic [7:0]            mem_data;

    modport master (
        output data_request, addr, rd_next, mem_data,
        input  data_ack, data, mem_rd, mem_addr
    );

    modport slave (
        input  data_request, addr, rd_next, mem_data,
        output data_ack, data, mem_rd, mem_addr
    );
endinterface

// File: rtl/lcd_page_buffer.sv
// lcd_page_buffer: fetches one 64x8-pixel tile from a row-major 1-bpp image ROM,
// transposes it into 64 KS0108 column bytes (bit r = pixel row r), acknowledges the
// tile, then serves the column bytes in order, advancing on rd_next.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - lcd_page_buffer_if.slave (request/ack/read side and ROM read side)
module lcd_page_buffer #(
    parameter int unsigned ADDR_W   = 7,
    parameter bit          MSB_LEFT = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    lcd_page_buffer_if.slave    bus
);
    localparam int unsigned MA_W  = ADDR_W + 6;
    localparam int unsigned IDX_W = 6;
    localparam int unsigned COLS  = 64;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_ACK
    } state_t;

    state_t              r_state, w_state_nxt;
    logic                r_data_ack, w_data_ack_nxt;
    logic                r_mem_rd, w_mem_rd_nxt;
    logic [MA_W-1:0]     r_mem_addr, w_mem_addr_nxt;
    logic [ADDR_W-1:0]   r_tile, w_tile_nxt;
    logic [IDX_W-1:0]    r_idx, w_idx_nxt;
    logic [IDX_W-1:0]    w_idx_inc;
    logic [IDX_W-1:0]    r_rd_ptr;
    logic                w_cap;
    logic                w_last;
    logic [7:0]          w_src_bits;
    logic [7:0]          r_buf [COLS];

    assign w_idx_inc = r_idx + IDX_W'(1);

    // Source byte reordered so that bit k is the k-th pixel from the left.
    assign w_src_bits = MSB_LEFT ? {<<{bus.mem_data}} : bus.mem_data;

    // State register and fetch bookkeeping registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_data_ack <= 1'b0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= '0;
            r_tile     <= '0;
            r_idx      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_data_ack <= w_data_ack_nxt;
            r_mem_rd   <= w_mem_rd_nxt;
            r_mem_addr <= w_mem_addr_nxt;
            r_tile     <= w_tile_nxt;
            r_idx      <= w_idx_nxt;
        end
    end

    // Next-state and next-output logic. In FETCH, r_idx names the address presented
    // last cycle, whose ROM data is valid now and is captured on this edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_data_ack_nxt = r_data_ack;
        w_mem_rd_nxt   = r_mem_rd;
        w_mem_addr_nxt = r_mem_addr;
        w_tile_nxt     = r_tile;
        w_idx_nxt      = r_idx;
        w_cap          = 1'b0;
        w_last         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_data_ack_nxt = 1'b0;
                if (bus.data_request) begin
                    w_tile_nxt     = bus.addr;
                    w_idx_nxt      = '0;
                    w_mem_rd_nxt   = 1'b1;
                    w_mem_addr_nxt = {bus.addr, IDX_W'(0)};
                    w_state_nxt    = S_FETCH;
                end
            end
            S_FETCH: begin
                w_cap = 1'b1;
                if (r_idx == IDX_W'(COLS - 1)) begin
                    w_last         = 1'b1;
                    w_mem_rd_nxt   = 1'b0;
                    w_data_ack_nxt = 1'b1;
                    w_state_nxt    = S_ACK;
                end else begin
                    w_idx_nxt      = w_idx_inc;
                    w_mem_addr_nxt = {r_tile, w_idx_inc};
                end
            end
            S_ACK: begin
                if (!bus.data_request) begin
                    w_data_ack_nxt = 1'b0;
                    w_state_nxt    = S_IDLE;
                end
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_data_ack_nxt = 1'b0;
                w_mem_rd_nxt   = 1'b0;
            end
        endcase
    end

    // Read pointer: cleared on the final capture (wins over rd_next), frozen in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= '0;
        end else if (w_last) begin
            r_rd_ptr <= '0;
        end else if (bus.rd_next && (r_state != S_FETCH)) begin
            r_rd_ptr <= r_rd_ptr + IDX_W'(1);
        end
    end

    // Transpose: ROM byte (row r, bytecol b) lands in bit r of columns 8b..8b+7.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < COLS; c++) begin
                r_buf[c] <= '0;
            end
        end else if (w_cap) begin
            for (int k = 0; k < 8; k++) begin
                r_buf[{r_idx[2:0], 3'(k)}][r_idx[5:3]] <= w_src_bits[k];
            end
        end
    end

    assign bus.data_ack = r_data_ack;
    assign bus.mem_rd   = r_mem_rd;
    assign bus.mem_addr = r_mem_addr;
    assign bus.data     = r_buf[r_rd_ptr];

endmodule

// File: tb/tb_lcd_page_buffer.sv
// tb_lcd_page_buffer: self-checking bench for lcd_page_buffer. A behavioural ROM answers
// reads; expected ROM addresses and column bytes go through scoreboard queues.
module tb_lcd_page_buffer;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned MA_W   = ADDR_W + 6;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    lcd_page_buffer_if #(.ADDR_W(ADDR_W)) bus ();

    lcd_page_buffer #(.ADDR_W(ADDR_W), .MSB_LEFT(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_pass     = 0;
    int n_total    = 0;
    int rom_mode   = 0;
    int rd_count   = 0;
    int ack_cycles = 0;

    logic [MA_W-1:0] exp_addr_q [$];
    logic [7:0]      exp_data_q [$];
    logic [MA_W-1:0] m_exp;

    // Image ROM contents: mode 0 = diagonal test pattern, mode 1 = hashed pattern.
    function automatic logic [7:0] rom_byte(input logic [MA_W-1:0] a);
        int v;
        v = int'(a);
        if (rom_mode == 0) return (a[5:3] == a[2:0]) ? 8'h80 : 8'h00;
        return 8'((v * 37) ^ (v >> 3) ^ 90);
    endfunction

    // Reference column byte: bit r = pixel (row r, column c) of the tile, MSB leftmost.
    function automatic logic [7:0] col_byte(input logic [ADDR_W-1:0] tile, input int c);
        logic [7:0] res;
        logic [7:0] src;
        logic [2:0] b;
        int         k;
        res = '0;
        b   = 3'(c / 8);
        k   = c % 8;
        for (int r = 0; r < 8; r++) begin
            src    = rom_byte({tile, 3'(r), b});
            res[r] = src[7 - k];
        end
        return res;
    endfunction

    task automatic push_burst(input logic [ADDR_W-1:0] tile);
        for (int i = 0; i < 64; i++) exp_addr_q.push_back({tile, 6'(i)});
    endtask

    // ROM data becomes valid in the second half of the cycle after the address.
    always @(negedge clk) bus.mem_data <= bus.mem_rd ? rom_byte(bus.mem_addr) : 8'h00;

    // Scoreboard for ROM reads and ack-cycle counter.
    always @(negedge clk) begin
        if (bus.data_ack) ack_cycles++;
        if (rst_n && bus.mem_rd) begin
            rd_count++;
            n_total++;
            if (exp_addr_q.size() == 0) begin
                $display("FAIL mem_addr_unexpected: got %h, expected no read", bus.mem_addr);
            end else begin
                m_exp = exp_addr_q.pop_front();
                if (bus.mem_addr !== m_exp)
                    $display("FAIL mem_addr: got %h, expected %h", bus.mem_addr, m_exp);
                else
                    n_pass++;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    task automatic test_reset();
        int base;
        rst_n = 1'b0;
        bus.data_request = 1'b0;
        bus.addr = '0;
        bus.rd_next = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        n_total++; if (bus.data_ack !== 1'b0) $display("FAIL reset_ack: got %b expected 0", bus.data_ack); else n_pass++;
        n_total++; if (bus.mem_rd !== 1'b0) $display("FAIL reset_mem_rd: got %b expected 0", bus.mem_rd); else n_pass++;
        n_total++; if (bus.data !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.data); else n_pass++;
        n_total++; if (bus.mem_addr !== '0) $display("FAIL reset_mem_addr: got %h expected 0", bus.mem_addr); else n_pass++;
        base = rd_count;
        repeat (100) @(negedge clk);
        #1;
        n_total++; if (rd_count - base !== 0) $display("FAIL idle_reads: got %0d expected 0", rd_count - base); else n_pass++;
        n_total++; if (bus.data_ack !== 1'b0) $display("FAIL idle_ack: got %b expected 0", bus.data_ack); else n_pass++;
    endtask

    task automatic test_single_fetch();
        int base;
        int cyc;
        rom_mode = 0;
        push_burst(7'h05);
        base = rd_count;
        @(negedge clk);
        bus.addr = 7'h05;
        bus.data_request = 1'b1;
        @(posedge clk); #1;
        n_total++; if (bus.mem_rd !== 1'b1) $display("FAIL fetch_start_rd: got %b expected 1", bus.mem_rd); else n_pass++;
        n_total++; if (bus.mem_addr !== 13'h0140) $display("FAIL fetch_first_addr: got %h expected 0140", bus.mem_addr); else n_pass++;
        cyc = 0;
        while (bus.data_ack !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_total++; if (cyc !== 64) $display("FAIL fill_latency: got %0d expected 64", cyc); else n_pass++;
        n_total++; if (rd_count - base !== 64) $display("FAIL fetch_reads: got %0d expected 64", rd_count - base); else n_pass++;
        n_total++; if (bus.mem_rd !== 1'b0) $display("FAIL fetch_rd_drop: got %b expected 0", bus.mem_rd); else n_pass++;
        n_total++; if (bus.data !== col_byte(7'h05, 0)) $display("FAIL ack_first_byte: got %h expected %h", bus.data, col_byte(7'h05, 0)); else n_pass++;
        n_total++; if (exp_addr_q.size() !== 0) $display("FAIL fetch_missing_reads: got %0d left expected 0", exp_addr_q.size()); else n_pass++;
    endtask

    task automatic test_streaming();
        logic [7:0] e;
        @(negedge clk);
        bus.data_request = 1'b0;
        @(posedge clk); #1;
        n_total++; if (bus.data_ack !== 1'b0) $display("FAIL stream_ack_fall: got %b expected 0", bus.data_ack); else n_pass++;
        for (int p = 0; p < 65; p++) begin
            exp_data_q.push_back(col_byte(7'h05, p % 64));
            @(negedge clk);
            bus.rd_next = 1'b1;
            #1;
            e = exp_data_q.pop_front();
            n_total++; if (bus.data !== e) $display("FAIL stream_byte[%0d]: got %h expected %h", p, bus.data, e); else n_pass++;
            @(negedge clk);
            bus.rd_next = 1'b0;
        end
    endtask

    task automatic test_drop_mid_fetch();
        int base_rd;
        int base_ack;
        int cyc;
        rom_mode = 1;
        push_burst(7'h12);
        base_rd  = rd_count;
        base_ack = ack_cycles;
        @(negedge clk);
        bus.addr = 7'h12;
        bus.data_request = 1'b1;
        bus.rd_next = 1'b1;
        @(posedge clk);
        repeat (20) @(posedge clk);
        @(negedge clk);
        bus.data_request = 1'b0;
        bus.addr = 7'h7F;
        cyc = 0;
        while (bus.data_ack !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_total++; if (bus.data_ack !== 1'b1) $display("FAIL drop_ack_seen: got %b expected 1", bus.data_ack); else n_pass++;
        n_total++; if (bus.data !== col_byte(7'h12, 0)) $display("FAIL drop_ptr_clear: got %h expected %h", bus.data, col_byte(7'h12, 0)); else n_pass++;
        @(negedge clk);
        bus.rd_next = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        n_total++; if (ack_cycles - base_ack !== 1) $display("FAIL drop_ack_len: got %0d expected 1", ack_cycles - base_ack); else n_pass++;
        n_total++; if (rd_count - base_rd !== 64) $display("FAIL drop_reads: got %0d expected 64", rd_count - base_rd); else n_pass++;
        n_total++; if (bus.mem_rd !== 1'b0) $display("FAIL drop_idle_rd: got %b expected 0", bus.mem_rd); else n_pass++;
        n_total++; if (bus.data !== col_byte(7'h12, 0)) $display("FAIL drop_persist: got %h expected %h", bus.data, col_byte(7'h12, 0)); else n_pass++;
        n_total++; if (exp_addr_q.size() !== 0) $display("FAIL drop_missing_reads: got %0d left expected 0", exp_addr_q.size()); else n_pass++;
    endtask

    task automatic test_held_request();
        int base_rd;
        int cyc;
        logic [7:0] e;
        rom_mode = 1;
        push_burst(7'h2A);
        base_rd = rd_count;
        @(negedge clk);
        bus.addr = 7'h2A;
        bus.data_request = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        n_total++; if (rd_count - base_rd !== 64) $display("FAIL held_reads: got %0d expected 64", rd_count - base_rd); else n_pass++;
        n_total++; if (bus.data_ack !== 1'b1) $display("FAIL held_ack: got %b expected 1", bus.data_ack); else n_pass++;
        for (int p = 0; p < 64; p++) begin
            exp_data_q.push_back(col_byte(7'h2A, p));
            @(negedge clk);
            bus.rd_next = 1'b1;
            #1;
            e = exp_data_q.pop_front();
            n_total++; if (bus.data !== e) $display("FAIL held_byte[%0d]: got %h expected %h", p, bus.data, e); else n_pass++;
            @(negedge clk);
            bus.rd_next = 1'b0;
        end
        @(negedge clk);
        bus.data_request = 1'b0;
        @(negedge clk);
        bus.data_request = 1'b1;
        bus.addr = 7'h33;
        push_burst(7'h33);
        base_rd = rd_count;
        @(posedge clk); #1;
        n_total++; if (bus.mem_rd !== 1'b1) $display("FAIL rerequest_start: got %b expected 1", bus.mem_rd); else n_pass++;
        n_total++; if (bus.mem_addr !== {7'h33, 6'd0}) $display("FAIL rerequest_addr: got %h expected %h", bus.mem_addr, {7'h33, 6'd0}); else n_pass++;
        cyc = 0;
        while (bus.data_ack !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_total++; if (cyc !== 64) $display("FAIL rerequest_latency: got %0d expected 64", cyc); else n_pass++;
        n_total++; if (rd_count - base_rd !== 64) $display("FAIL rerequest_reads: got %0d expected 64", rd_count - base_rd); else n_pass++;
        n_total++; if (bus.data !== col_byte(7'h33, 0)) $display("FAIL rerequest_byte0: got %h expected %h", bus.data, col_byte(7'h33, 0)); else n_pass++;
        @(negedge clk);
        bus.data_request = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_fetch();
        int base_rd;
        int base_ack;
        int cyc;
        rom_mode = 1;
        push_burst(7'h44);
        base_rd = rd_count;
        @(negedge clk);
        bus.addr = 7'h44;
        bus.data_request = 1'b1;
        @(posedge clk);
        repeat (30) @(posedge clk);
        #2;
        n_total++; if (bus.mem_addr !== {7'h44, 6'd30}) $display("FAIL rstmid_addr: got %h expected %h", bus.mem_addr, {7'h44, 6'd30}); else n_pass++;
        rst_n = 1'b0;
        bus.data_request = 1'b0;
        base_ack = ack_cycles;
        #1;
        n_total++; if (bus.mem_rd !== 1'b0) $display("FAIL rstmid_rd: got %b expected 0", bus.mem_rd); else n_pass++;
        n_total++; if (bus.data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", bus.data); else n_pass++;
        n_total++; if (rd_count - base_rd !== 30) $display("FAIL rstmid_reads: got %0d expected 30", rd_count - base_rd); else n_pass++;
        exp_addr_q.delete();
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        n_total++; if (ack_cycles - base_ack !== 0) $display("FAIL rstmid_no_ack: got %0d expected 0", ack_cycles - base_ack); else n_pass++;
        for (int p = 0; p < 8; p++) begin
            @(negedge clk);
            bus.rd_next = 1'b1;
            #1;
            n_total++; if (bus.data !== 8'h00) $display("FAIL rstmid_cleared[%0d]: got %h expected 00", p, bus.data); else n_pass++;
            @(negedge clk);
            bus.rd_next = 1'b0;
        end
        push_burst(7'h44);
        base_rd = rd_count;
        @(negedge clk);
        bus.data_request = 1'b1;
        @(posedge clk);
        cyc = 0;
        while (bus.data_ack !== 1'b1 && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        n_total++; if (cyc !== 64) $display("FAIL rstmid_refetch_latency: got %0d expected 64", cyc); else n_pass++;
        n_total++; if (rd_count - base_rd !== 64) $display("FAIL rstmid_refetch_reads: got %0d expected 64", rd_count - base_rd); else n_pass++;
        n_total++; if (bus.data !== col_byte(7'h44, 0)) $display("FAIL rstmid_refetch_byte0: got %h expected %h", bus.data, col_byte(7'h44, 0)); else n_pass++;
        @(negedge clk);
        bus.data_request = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (exp_addr_q.size() !== 0) $display("FAIL final_missing_reads: got %0d left expected 0", exp_addr_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_streaming();
        test_drop_mid_fetch();
        test_held_request();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
